// File: rtl/uart_rx_controller_if.sv
// Signal bundle between the UART Rx sequencer and its line/de-framer neighbours.
// The slave modport is the sequencer's view.
interface uart_rx_controller_if;
    logic        baud_tick;
    logic        rx;
    logic        parity_type;
    logic [10:0] data_parll;
    logic        recieved_flag;
    logic        busy;
    logic        parity_error;
    logic        stop_error;

    modport master (
        output baud_tick, rx, parity_type,
        input  data_parll, recieved_flag, busy, parity_error, stop_error
    );

    modport slave (
        input  baud_tick, rx, parity_type,
        output data_parll, recieved_flag, busy, parity_error, stop_error
    );
endinterface

// File: rtl/uart_rx_controller.sv
// UART Rx sequencer: synchronises rx, qualifies the start bit on oversampling ticks,
// samples each bit at mid-bit and presents the completed 11-bit frame with a strobe.
//   state | meaning
//   IDLE  | line idle, waiting for a low sample on a tick
//   START | counting to mid-start-bit to reject glitches
//   SHIFT | sampling 8 data bits and parity at mid-bit
//   STOP  | sampling stop bit, then completing the frame
module uart_rx_controller #(
    parameter int OVERSAMPLE = 16
) (
    input logic               clock,
    input logic               reset_n,
    uart_rx_controller_if.slave bus
);
    localparam int MID = OVERSAMPLE / 2;
    localparam int TW  = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] TICK_MID = TW'(MID - 1);
    localparam logic [TW-1:0] TICK_END = TW'(OVERSAMPLE - 1);

    typedef enum logic [1:0] {IDLE, START, SHIFT, STOP} state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [3:0]    bit_q, bit_d;
    logic [9:0]    shift_q, shift_d;
    logic [10:0]   data_q, data_d;
    logic          rcv_q, rcv_d;
    logic          busy_q, busy_d;
    logic          perr_q, perr_d;
    logic          serr_q, serr_d;
    logic          rx_meta_q, rx_s_q;
    logic [10:0]   frame;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            state_q   <= IDLE;
            tick_q    <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            data_q    <= 11'h7FF;
            rcv_q     <= 1'b0;
            busy_q    <= 1'b0;
            perr_q    <= 1'b0;
            serr_q    <= 1'b0;
        end else begin
            rx_meta_q <= bus.rx;
            rx_s_q    <= rx_meta_q;
            state_q   <= state_d;
            tick_q    <= tick_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            rcv_q     <= rcv_d;
            busy_q    <= busy_d;
            perr_q    <= perr_d;
            serr_q    <= serr_d;
        end
    end

    // The frame as it would look if the current sample were shifted in now.
    assign frame = {shift_q, rx_s_q};

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        rcv_d   = 1'b0;
        busy_d  = busy_q;
        perr_d  = perr_q;
        serr_d  = serr_q;

        unique case (state_q)
            IDLE: begin
                if (bus.baud_tick && !rx_s_q) begin
                    tick_d  = TW'(1);
                    state_d = START;
                end
            end
            START: begin
                if (bus.baud_tick) begin
                    if (tick_q == TICK_MID) begin
                        tick_d = '0;
                        if (!rx_s_q) begin
                            shift_d = {shift_q[8:0], 1'b0};
                            bit_d   = '0;
                            busy_d  = 1'b1;
                            state_d = SHIFT;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end
            SHIFT: begin
                if (bus.baud_tick) begin
                    if (tick_q == TICK_END) begin
                        tick_d  = '0;
                        shift_d = frame[9:0];
                        bit_d   = bit_q + 1'b1;
                        if (bit_q == 4'd8) state_d = STOP;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end
            STOP: begin
                if (bus.baud_tick) begin
                    if (tick_q == TICK_END) begin
                        tick_d  = '0;
                        bit_d   = '0;
                        shift_d = frame[9:0];
                        data_d  = frame;
                        rcv_d   = 1'b1;
                        busy_d  = 1'b0;
                        perr_d  = (^frame[9:1]) != ~bus.parity_type;
                        serr_d  = ~frame[0];
                        state_d = IDLE;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.data_parll    = data_q;
    assign bus.recieved_flag = rcv_q;
    assign bus.busy          = busy_q;
    assign bus.parity_error  = perr_q;
    assign bus.stop_error    = serr_q;
endmodule

// File: tb/tb_uart_rx_controller.sv
// Directed bench for uart_rx_controller: table of frames with hand-computed results,
// plus glitch, back-to-back and mid-frame reset sequences.
module tb_uart_rx_controller;
    logic clock = 1'b0;
    logic reset_n = 1'b0;

    uart_rx_controller_if bus();

    uart_rx_controller #(.OVERSAMPLE(16)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;
    int tdiv = 2;
    int cyc = 0;
    int strobe_cnt = 0;
    int strobe_cyc [$];
    logic [10:0] cap_frame [$];
    logic busy_seen = 1'b0;

    typedef struct {
        logic [7:0]  d;
        logic        par;
        logic        stp;
        logic        ptype;
        int          div;
        logic [10:0] exp_frame;
        logic        exp_perr;
        logic        exp_serr;
    } vec_t;

    vec_t vecs [8];

    // Tick generator: one-clock pulse every tdiv clocks (tdiv=1 holds it high).
    initial begin
        int ph;
        ph = 0;
        bus.baud_tick = 1'b0;
        forever begin
            @(negedge clock);
            ph = (ph + 1) % tdiv;
            bus.baud_tick = (ph == 0);
        end
    end

    always @(negedge clock) begin
        cyc++;
        if (bus.busy) busy_seen = 1'b1;
        if (bus.recieved_flag) begin
            strobe_cnt++;
            strobe_cyc.push_back(cyc);
            cap_frame.push_back(bus.data_parll);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic hold(input int ticks);
        repeat (ticks * tdiv) @(negedge clock);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stp, input int idle_ticks);
        logic [10:0] f;
        f = {1'b0, d, par, stp};
        for (int i = 10; i >= 0; i--) begin
            bus.rx = f[i];
            // A low stop bit is cut short so the line is high again before any re-qualification.
            hold((i == 0 && !stp) ? 12 : 16);
        end
        bus.rx = 1'b1;
        hold(idle_ticks);
    endtask

    initial begin
        int s0;
        logic [10:0] last_frame;

        vecs[0] = '{8'hA5, 1'b0, 1'b1, 1'b1, 2, 11'b0_10100101_0_1, 1'b0, 1'b0};
        vecs[1] = '{8'hA5, 1'b1, 1'b1, 1'b1, 2, 11'b0_10100101_1_1, 1'b1, 1'b0};
        vecs[2] = '{8'hA5, 1'b1, 1'b1, 1'b0, 2, 11'b0_10100101_1_1, 1'b0, 1'b0};
        vecs[3] = '{8'hA5, 1'b0, 1'b0, 1'b1, 2, 11'b0_10100101_0_0, 1'b0, 1'b1};
        vecs[4] = '{8'hA5, 1'b0, 1'b1, 1'b1, 2, 11'b0_10100101_0_1, 1'b0, 1'b0};
        vecs[5] = '{8'h00, 1'b1, 1'b1, 1'b0, 1, 11'b0_00000000_1_1, 1'b0, 1'b0};
        vecs[6] = '{8'hFF, 1'b0, 1'b1, 1'b1, 2, 11'b0_11111111_0_1, 1'b0, 1'b0};
        vecs[7] = '{8'hFF, 1'b0, 1'b1, 1'b0, 2, 11'b0_11111111_0_1, 1'b1, 1'b0};

        bus.rx = 1'b1;
        bus.parity_type = 1'b1;
        reset_n = 1'b0;
        repeat (4) @(negedge clock);
        reset_n = 1'b1;
        repeat (4) @(negedge clock);

        chk("rst_data", 32'(bus.data_parll), 32'h7FF);
        chk("rst_flag", 32'(bus.recieved_flag), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_perr", 32'(bus.parity_error), 32'd0);
        chk("rst_serr", 32'(bus.stop_error), 32'd0);

        foreach (vecs[i]) begin
            tdiv = vecs[i].div;
            bus.parity_type = vecs[i].ptype;
            s0 = strobe_cnt;
            send_frame(vecs[i].d, vecs[i].par, vecs[i].stp, 16);
            chk($sformatf("v%0d_strobes", i), 32'(strobe_cnt - s0), 32'd1);
            if (strobe_cnt > s0)
                chk($sformatf("v%0d_cap_frame", i), 32'(cap_frame[cap_frame.size()-1]), 32'(vecs[i].exp_frame));
            chk($sformatf("v%0d_data_hold", i), 32'(bus.data_parll), 32'(vecs[i].exp_frame));
            chk($sformatf("v%0d_perr", i), 32'(bus.parity_error), 32'(vecs[i].exp_perr));
            chk($sformatf("v%0d_serr", i), 32'(bus.stop_error), 32'(vecs[i].exp_serr));
            chk($sformatf("v%0d_busy", i), 32'(bus.busy), 32'd0);
        end
        tdiv = 2;
        last_frame = vecs[7].exp_frame;

        // Glitch: 4 ticks low is rejected before mid-start-bit.
        busy_seen = 1'b0;
        s0 = strobe_cnt;
        bus.rx = 1'b0;
        hold(4);
        bus.rx = 1'b1;
        hold(32);
        chk("glitch_busy", 32'(busy_seen), 32'd0);
        chk("glitch_strobes", 32'(strobe_cnt - s0), 32'd0);
        chk("glitch_data", 32'(bus.data_parll), 32'(last_frame));
        chk("glitch_perr", 32'(bus.parity_error), 32'd1);

        // Back-to-back frames with no idle between stop and next start.
        bus.parity_type = 1'b1;
        s0 = strobe_cnt;
        send_frame(8'h3C, 1'b0, 1'b1, 0);
        send_frame(8'hC3, 1'b0, 1'b1, 16);
        chk("b2b_strobes", 32'(strobe_cnt - s0), 32'd2);
        if (strobe_cnt - s0 == 2) begin
            chk("b2b_frame0", 32'(cap_frame[s0]), 32'(11'b0_00111100_0_1));
            chk("b2b_frame1", 32'(cap_frame[s0+1]), 32'(11'b0_11000011_0_1));
            chk("b2b_spacing_ok", 32'((strobe_cyc[s0+1] - strobe_cyc[s0]) inside {[348:356]}), 32'd1);
        end
        chk("b2b_perr", 32'(bus.parity_error), 32'd0);
        chk("b2b_serr", 32'(bus.stop_error), 32'd0);

        // Corrupt the error flag, then reset partway through a frame.
        bus.parity_type = 1'b0;
        send_frame(8'hFF, 1'b0, 1'b1, 16);
        chk("pre_rst_perr", 32'(bus.parity_error), 32'd1);
        s0 = strobe_cnt;
        bus.rx = 1'b0;
        hold(16);
        bus.rx = 1'b1;
        hold(16);
        bus.rx = 1'b0;
        hold(48);
        chk("mid_busy", 32'(bus.busy), 32'd1);
        bus.rx = 1'b1;
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        hold(192);
        chk("mrst_strobes", 32'(strobe_cnt - s0), 32'd0);
        chk("mrst_data", 32'(bus.data_parll), 32'h7FF);
        chk("mrst_busy", 32'(bus.busy), 32'd0);
        chk("mrst_perr", 32'(bus.parity_error), 32'd0);
        chk("mrst_serr", 32'(bus.stop_error), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/uart_rx_controller.md
Name: uart_rx_controller

Overview:
Receive-side sequencer for the UART Rx path. It synchronises the serial line, detects and qualifies the start bit using 16x oversampling ticks, and samples each bit at mid-bit into an 11-bit frame register. When a frame completes it presents the frame together with a one-cycle received strobe, which the downstream de-framing stage uses as its enable. It also flags parity and stop-bit errors.

Parameters:
OVERSAMPLE, 16, baud_tick pulses per bit period; power of two, minimum 8.
MID, OVERSAMPLE/2, tick count from falling edge to mid-start-bit sample.

Ports:
clock  input  1  system clock; all logic on rising edge.
reset_n  input  1  synchronous active-low reset, sampled on clock rising edge.
baud_tick  input  1  one-clock pulse at OVERSAMPLE x baud rate.
rx  input  1  asynchronous serial line; idle high.
parity_type  input  1  0 = odd parity, 1 = even parity; sampled at frame completion.
data_parll  output  11  frame: [10]=start, [9:2]=data (first data bit received at [9]), [1]=parity, [0]=stop.
recieved_flag  output  1  one-clock pulse; data_parll is valid on this cycle.
busy  output  1  high from start qualification until the frame completes.
parity_error  output  1  parity mismatch in the last completed frame.
stop_error  output  1  stop bit sampled 0 in the last completed frame.

Behaviour:
- Synchroniser
  - 2-flop on rx (rx_s); both flops reset to 1.
  - All decisions use rx_s only.
- Reset values (reset_n=0 at a clock edge)
  - data_parll=11'h7FF; recieved_flag=0; busy=0; parity_error=0; stop_error=0.
  - State=IDLE; tick_cnt=0; bit_cnt=0.
  - Reset mid-frame aborts the frame; no strobe is generated.
- Counters
  - tick_cnt is 4 bits wide for OVERSAMPLE=16 (generally log2 OVERSAMPLE) and advances only on baud_tick.
  - bit_cnt is 4 bits wide and counts 0..9.
- States
  - IDLE
    - On baud_tick with rx_s=0: tick_cnt=1, go to START.
    - Otherwise stay in IDLE.
  - START
    - On each baud_tick, tick_cnt increments.
    - When tick_cnt reaches MID-1 on a tick:
      - if rx_s=0: shift 0 in, tick_cnt=0, bit_cnt=0, busy=1, go to SHIFT.
      - if rx_s=1: treat as a glitch, go to IDLE; no flags change.
  - SHIFT
    - Sample on the baud_tick where tick_cnt=OVERSAMPLE-1 (mid-bit); tick_cnt wraps to 0.
    - Frame shifts left with rx_s into bit 0; bit_cnt increments.
    - After 9 samples (8 data + parity, bit_cnt=9), go to STOP.
  - STOP
    - At the next mid-bit sample, shift in rx_s; the frame is now complete.
    - On the same clock: recieved_flag=1 for exactly one cycle; busy=0; go to IDLE.
    - Errors are registered from the completed frame:
      - parity_error = (^frame[9:1]) != ~parity_type. Odd: the data+parity ones count must be odd.
      - stop_error = ~frame[0].
- data_parll update rules
  - Updates only on the completion cycle.
  - Holds between frames.
  - Intermediate shift contents stay on an internal register, never on data_parll.
- Error flags hold until the next completed frame overwrites them.
- Back-to-back frames: IDLE is re-entered at mid-stop-bit, so a start edge half a bit later is detected normally.
- Latency: strobe asserts at the mid-stop-bit tick + 1 clock, i.e. about 10.5 bit periods after the start falling edge (+2 clocks of synchroniser delay).
- Line stuck low
  - The frame completes with stop_error=1; the controller returns to IDLE.
  - The low line immediately restarts start qualification.
- baud_tick held high every clock: legal; the controller operates at clock/OVERSAMPLE baud.
- No baud_tick: state and counters freeze.

Test Plan:
- Reset: drive reset_n=0 mid-frame, then release -> data_parll=11'h7FF, all flags 0, state IDLE, no recieved_flag pulse.
- Valid frame, parity_type=1 (even):
  - stimulus: start 0, data bits 1,0,1,0,0,1,0,1, parity 0, stop 1.
  - response: one recieved_flag pulse; data_parll=11'b0_10100101_0_1; parity_error=0; stop_error=0.
- Same data with parity bit 1 and parity_type=1 -> parity_error=1, stop_error=0. Repeat with parity_type=0 -> parity_error=0.
- Glitch: rx low for 4 ticks, then high -> returns to IDLE; busy never asserts; no strobe; outputs unchanged.
- Framing error: valid frame with stop bit 0 -> stop_error=1, data_parll[0]=0. Next good frame clears stop_error to 0.
- Back-to-back: two frames with zero idle gap (0x3C, then 0xC3) -> two strobes about 11 bit periods apart, both data fields correct, no errors.
